// File: rtl/aes_spi_selftest_seq_pkg.sv
// rtl/aes_spi_selftest_seq_pkg.sv - shared types, widths and frame helpers for the AES-over-SPI self-test sequencer
package aes_spi_pkg;

    localparam int FRAME_W = 258;
    localparam int BLK_W   = 128;

    localparam logic [1:0] KEY128 = 2'b00;
    localparam logic [1:0] KEY192 = 2'b01;
    localparam logic [1:0] KEY256 = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_KEY_E, S_MSG_E, S_WAIT_E, S_RD_E,
        S_KEY_D, S_CT_D, S_WAIT_D, S_RD_D, S_CHECK, S_NEXT, S_DONE
    } state_e;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] key_len,
                                                       input logic [255:0] key);
        return {key_len, key};
    endfunction

    function automatic logic is_xfer(input state_e s);
        return s inside {S_KEY_E, S_MSG_E, S_RD_E, S_KEY_D, S_CT_D, S_RD_D};
    endfunction

endpackage

// File: rtl/aes_spi_selftest_seq_if.sv
// rtl/aes_spi_selftest_seq_if.sv - SPI_Main master-port bundle (sel/start/tx/rx/done)
interface aes_spi_selftest_seq_if;
    import aes_spi_pkg::*;

    logic               spi_sel;
    logic               spi_start;
    logic [FRAME_W-1:0] spi_tx;
    logic [BLK_W-1:0]   spi_rx;
    logic               spi_done;

    modport master (output spi_sel, spi_start, spi_tx, input spi_rx, spi_done);
    modport slave  (input spi_sel, spi_start, spi_tx, output spi_rx, spi_done);
endinterface

// File: rtl/aes_spi_xfer_ctl.sv
// rtl/aes_spi_xfer_ctl.sv - per-transfer start pulse, spi_done rising-edge detect and watchdog
module aes_spi_xfer_ctl #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic xfer_enter,
    input  logic xfer_active,
    input  logic spi_done,
    output logic spi_start,
    output logic xfer_done,
    output logic xfer_timeout
);
    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic             start_q;
    logic             done_q;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             done_evt;

    assign done_evt     = spi_done & ~done_q;
    assign spi_start    = start_q;
    assign xfer_done    = xfer_active & done_evt;
    assign xfer_timeout = xfer_active & ~done_evt & (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q;
        if (xfer_enter)
            wd_d = '0;
        else if (xfer_active && wd_q != WD_LAST)
            wd_d = wd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            wd_q    <= '0;
        end else begin
            start_q <= xfer_enter;
            done_q  <= spi_done;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: rtl/aes_spi_selftest_seq.sv
// rtl/aes_spi_selftest_seq.sv - AES encrypt/decrypt round-trip self-test sequencer; optional AES_SELFTEST_KAT_CHECK_EN
module aes_spi_selftest_seq
    import aes_spi_pkg::*;
#(
    parameter int NUM_VEC     = 3,
    parameter int IDX_W       = 8,
    parameter int WAIT_CYC    = 70,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ENC_SEL     = 0,
    parameter int DEC_SEL     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_test,
    input  logic                run_all,
    input  logic [IDX_W-1:0]    vec_sel,
    output logic [IDX_W-1:0]    vec_idx,
    input  logic [FRAME_W-1:0]  rom_key,
    input  logic [BLK_W-1:0]    rom_msg,
    input  logic [BLK_W-1:0]    rom_ct,
    aes_spi_selftest_seq_if.master spi,
    output logic                busy,
    output logic                pass,
    output logic                fail,
    output logic [IDX_W:0]      err_count,
    output logic [IDX_W-1:0]    fail_idx,
    output logic                timeout
);
    localparam int               WAIT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);
    localparam logic [IDX_W:0]    NUM_VEC_W = (IDX_W+1)'(NUM_VEC);

    state_e             state_q, state_d;
    logic               run_all_q, run_all_d;
    logic [IDX_W-1:0]   vec_idx_q, vec_idx_d;
    logic [FRAME_W-1:0] key_frame_q, key_frame_d;
    logic [BLK_W-1:0]   msg_q, msg_d;
    logic [BLK_W-1:0]   ct_exp_q, ct_exp_d;
    logic               kat_bad_q, kat_bad_d;
    logic [BLK_W-1:0]   ct_rx_q, ct_rx_d;
    logic [BLK_W-1:0]   pt_rx_q, pt_rx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;
    logic [IDX_W:0]     err_q, err_d;
    logic [IDX_W-1:0]   fidx_q, fidx_d;
    logic               vec_bad;
    logic               xfer_enter, xfer_done, xfer_timeout;

    aes_spi_xfer_ctl #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_xfer (
        .clk          (clk),
        .rst_n        (rst_n),
        .xfer_enter   (xfer_enter),
        .xfer_active  (is_xfer(state_q)),
        .spi_done     (spi.spi_done),
        .spi_start    (spi.spi_start),
        .xfer_done    (xfer_done),
        .xfer_timeout (xfer_timeout)
    );

    assign xfer_enter = is_xfer(state_d) && (state_d != state_q);
    assign vec_idx    = vec_idx_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign err_count  = err_q;
    assign fail_idx   = fidx_q;
    assign timeout    = timeout_q;
    assign spi.spi_sel = (state_q inside {S_KEY_D, S_CT_D, S_RD_D}) ? 1'(DEC_SEL) : 1'(ENC_SEL);

`ifndef AES_SELFTEST_KAT_CHECK_EN
    logic unused_rom_ct;
    assign unused_rom_ct = ^rom_ct;
`endif

    always_comb begin
        spi.spi_tx = '0;
        case (state_q)
            S_KEY_E, S_KEY_D: spi.spi_tx = key_frame_q;
            S_MSG_E:          spi.spi_tx = {{(FRAME_W-BLK_W){1'b0}}, msg_q};
            S_CT_D:           spi.spi_tx = {{(FRAME_W-BLK_W){1'b0}}, ct_rx_q};
            default:          spi.spi_tx = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        run_all_d   = run_all_q;
        vec_idx_d   = vec_idx_q;
        key_frame_d = key_frame_q;
        msg_d       = msg_q;
        ct_exp_d    = ct_exp_q;
        kat_bad_d   = kat_bad_q;
        ct_rx_d     = ct_rx_q;
        pt_rx_d     = pt_rx_q;
        wait_d      = wait_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        fidx_d      = fidx_q;
        vec_bad     = 1'b0;

        case (state_q)
            S_IDLE: if (start_test) begin
                pass_d    = 1'b0;
                fail_d    = 1'b0;
                timeout_d = 1'b0;
                err_d     = '0;
                fidx_d    = '0;
                run_all_d = run_all;
                vec_idx_d = run_all ? '0 : vec_sel;
                // An out-of-range single vector is reported as one failure without touching the bus.
                if (!run_all && {1'b0, vec_sel} >= NUM_VEC_W) begin
                    err_d   = (IDX_W+1)'(1);
                    fidx_d  = vec_sel;
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                key_frame_d = build_frame(rom_key[257:256], rom_key[255:0]);
                msg_d       = rom_msg;
                kat_bad_d   = 1'b0;
`ifdef AES_SELFTEST_KAT_CHECK_EN
                ct_exp_d    = rom_ct;
`endif
                state_d     = S_KEY_E;
            end
            S_KEY_E: if (xfer_done) state_d = S_MSG_E;
            S_MSG_E: if (xfer_done) begin wait_d = '0; state_d = S_WAIT_E; end
            S_WAIT_E: if (wait_q == WAIT_LAST) state_d = S_RD_E; else wait_d = wait_q + 1'b1;
            S_RD_E: if (xfer_done) begin
                ct_rx_d = spi.spi_rx;
`ifdef AES_SELFTEST_KAT_CHECK_EN
                kat_bad_d = (spi.spi_rx != ct_exp_q);
`endif
                state_d = S_KEY_D;
            end
            S_KEY_D: if (xfer_done) state_d = S_CT_D;
            S_CT_D:  if (xfer_done) begin wait_d = '0; state_d = S_WAIT_D; end
            S_WAIT_D: if (wait_q == WAIT_LAST) state_d = S_RD_D; else wait_d = wait_q + 1'b1;
            S_RD_D: if (xfer_done) begin pt_rx_d = spi.spi_rx; state_d = S_CHECK; end
            S_CHECK: begin
                vec_bad = (pt_rx_q != msg_q) || kat_bad_q;
                state_d = S_NEXT;
            end
            S_NEXT: if (run_all_q && ({1'b0, vec_idx_q} < NUM_VEC_W - 1'b1)) begin
                vec_idx_d = vec_idx_q + 1'b1;
                state_d   = S_FETCH;
            end else begin
                state_d = S_DONE;
            end
            S_DONE: begin
                pass_d  = (err_q == '0) && !timeout_q;
                fail_d  = !pass_d;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (xfer_timeout) begin
            timeout_d = 1'b1;
            vec_bad   = 1'b1;
            state_d   = S_NEXT;
        end

        if (vec_bad) begin
            err_d = (&err_q) ? err_q : err_q + 1'b1;
            if (err_q == '0) fidx_d = vec_idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            run_all_q   <= 1'b0;
            vec_idx_q   <= '0;
            key_frame_q <= '0;
            msg_q       <= '0;
            ct_exp_q    <= '0;
            kat_bad_q   <= 1'b0;
            ct_rx_q     <= '0;
            pt_rx_q     <= '0;
            wait_q      <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            fidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            run_all_q   <= run_all_d;
            vec_idx_q   <= vec_idx_d;
            key_frame_q <= key_frame_d;
            msg_q       <= msg_d;
            ct_exp_q    <= ct_exp_d;
            kat_bad_q   <= kat_bad_d;
            ct_rx_q     <= ct_rx_d;
            pt_rx_q     <= pt_rx_d;
            wait_q      <= wait_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            fidx_q      <= fidx_d;
        end
    end
endmodule
